piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on `so`, qualified by `so_valid`.
- It is the transmit end of the serial link whose receive end is the team's existing 4-bit SIPO register.
- Sits between a word producer and the serial pin. Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits (legal range 2 to 32).
- LSB_FIRST, 0, bit order: 0 sends pi[WIDTH-1] first, 1 sends pi[0] first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- pi  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on pi.
- load_ready  output  1  transmitter can accept a word this cycle.
- so  output  1  serial data out (registered).
- so_valid  output  1  so carries a live bit this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse in the cycle the last bit of a frame is on so.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0, so=0, so_valid=0, busy=0, done=0. load_ready=1 while in IDLE, including during reset.
- Transfer: a word is accepted on a rising edge where load_valid && load_ready. pi is sampled only on that edge.
- States:
  - IDLE: so=0, so_valid=0, busy=0. On accept, go to SHIFT.
  - SHIFT: so_valid=1, busy=1. One bit per cycle.
  - PARITY: exists only with the optional feature.
- Latency: the first bit appears on so in the cycle after the accept edge. The frame occupies exactly WIDTH consecutive so_valid cycles.
- Bit order:
  - LSB_FIRST=0: MSB first, down to pi[0].
  - LSB_FIRST=1: pi[0] first, up to the MSB.
- Counter: a bit counter of width clog2(WIDTH+1) counts transmitted bits and identifies the last bit. It never wraps mid-frame.
- load_ready = (state==IDLE) || (last bit of frame is on so).
  - Accept during the last bit: the next word's first bit follows on the next cycle, and so_valid stays 1 continuously.
  - Without an accept at the last bit: return to IDLE next cycle. so_valid=0 and so=0.
- done: high exactly in the cycle the final frame bit (data or parity) is on so, for every frame, including back-to-back frames.
- load_valid while load_ready=0 is ignored. The producer must hold pi and load_valid; no word is lost or double-sent.
- pi changing mid-frame has no effect on the frame in flight.
- Reset mid-frame: the frame is aborted immediately (so_valid=0, so=0). After rst_n releases, the block waits in IDLE for a new load.
- No combinational path from pi to so.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra so_valid cycle carries even parity (XOR of all WIDTH data bits), in state PARITY.
  - Frame length = WIDTH+1 cycles. load_ready and done refer to the parity cycle, not the last data bit.
- Undefined: no PARITY state. Frame length = WIDTH cycles and behaviour is exactly as above.

Test Plan:
1. rst_n=0 for 2 cycles, then release with load_valid=0 -> so=0, so_valid=0, busy=0, done=0, load_ready=1 throughout.
2. WIDTH=4, LSB_FIRST=0, load pi=4'b1011 -> on the 4 cycles after accept so=1,0,1,1 with so_valid=1; done on the 4th; so_valid=0 on the 5th. Chaining so into the SIPO reproduces po=4'b1011.
3. Back-to-back: pi=4'b1100 then 4'b0011, load_valid held high -> so=1,1,0,0,0,0,1,1 with so_valid continuously 1; done on cycles 4 and 8; load_ready high only in the accept cycle and on cycles 4 and 8.
4. LSB_FIRST=1, pi=4'b0001 -> so=1,0,0,0.
5. Reset mid-frame: assert rst_n=0 after 2 bits of 4'b1111 -> so and so_valid drop to 0 immediately without waiting for clk; no remaining bits are sent after release.
6. PISO_TX_PARITY_EN defined, pi=4'b0111 -> so=0,1,1,1,1 (parity=1), done on the 5th cycle; pi=4'b0110 gives parity bit 0.

Source files
------------

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx: parallel-in serial-out transmitter.
//
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per clock on `so`, qualified by `so_valid`. A new word can be accepted in
// the cycle the last bit of the current frame is on `so`, so back-to-back
// frames leave no idle gap on the serial line.
//
// Parameters:
//   WIDTH      data word width in bits (2..32)
//   LSB_FIRST  0: pi[WIDTH-1] goes out first; 1: pi[0] goes out first
//
// Optional feature (macro PISO_TX_PARITY_EN):
//   When defined, each frame is followed by one extra so_valid cycle that
//   carries even parity (XOR of the data bits). done/load_ready then refer to
//   that parity cycle instead of the last data bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   pi          parallel word to transmit
//   load_valid  producer has a word on pi
//   load_ready  transmitter accepts a word this cycle
//   so          serial data out (registered)
//   so_valid    so carries a live bit
//   busy        a frame is in progress
//   done        pulse while the final bit of a frame is on so
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;    // bits still waiting to go out
  logic [CW-1:0]    cnt_q,   cnt_d;      // data bits placed on so so far
  logic             so_q,       so_d;
  logic             so_valid_q, so_valid_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q,   parity_d;
`endif

  logic accept;
  logic next_bit;

  // done_q marks the last bit of the frame on so, which is exactly the other
  // moment a new word may be taken besides IDLE.
  assign load_ready = (state_q == IDLE) || done_q;
  assign accept     = load_valid && load_ready;
  assign next_bit   = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    so_d       = so_q;
    so_valid_d = so_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (accept) begin
      // First bit goes straight into so_q so it appears the cycle after accept.
      state_d    = SHIFT;
      so_d       = LSB_FIRST ? pi[0] : pi[WIDTH-1];
      shift_d    = LSB_FIRST ? (pi >> 1) : (pi << 1);
      cnt_d      = CW'(1);
      so_valid_d = 1'b1;
      busy_d     = 1'b1;
`ifdef PISO_TX_PARITY_EN
      parity_d   = ^pi;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
            so_d    = parity_q;
            done_d  = 1'b1;
`else
            state_d    = IDLE;
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            busy_d     = 1'b0;
            cnt_d      = '0;
`endif
          end else begin
            so_d    = next_bit;
            shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
            cnt_d   = cnt_q + CW'(1);
`ifndef PISO_TX_PARITY_EN
            done_d  = (cnt_d == LAST);
`endif
          end
        end
        default: begin
          // IDLE, or PARITY finishing without a follow-on word.
          state_d    = IDLE;
          so_d       = 1'b0;
          so_valid_d = 1'b0;
          busy_d     = 1'b0;
          cnt_d      = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shift register is reset along with the control flops; it is
  // small, and a cleared value keeps so at 0 after an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PISO_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx: self-checking bench for piso_tx (WIDTH=4).
// Two instances share clock, reset and load inputs: one MSB-first, one
// LSB-first. On every modelled accept the expected bit stream of each instance
// is pushed to its queue; each following clock pops one entry and compares so,
// so_valid, done, busy and load_ready.
// -----------------------------------------------------------------------------
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pi = '0;
  logic         load_valid = 1'b0;

  logic ready0, so0, so_valid0, busy0, done0;
  logic ready1, so1, so_valid1, busy1, done1;

  exp_t q0[$];
  exp_t q1[$];
  logic exp_ready = 1'b1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pi(pi), .load_valid(load_valid),
    .load_ready(ready0), .so(so0), .so_valid(so_valid0), .busy(busy0),
    .done(done0)
  );

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .pi(pi), .load_valid(load_valid),
    .load_ready(ready1), .so(so1), .so_valid(so_valid1), .busy(busy1),
    .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial streams for one accepted word.
  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = w[W-1-i];
      e.last = (i == FL - 1);
      q0.push_back(e);
      e.b = w[i];
      q1.push_back(e);
    end
`ifdef PISO_TX_PARITY_EN
    e.b = ^w;
    e.last = 1'b1;
    q0.push_back(e);
    q1.push_back(e);
`endif
  endtask

  task automatic check_lane(input string tag, inout exp_t q[$],
                            input logic so_o, input logic sv_o,
                            input logic dn_o, input logic bz_o);
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, ".so"},       32'(so_o), 32'(e.b));
      check({tag, ".so_valid"}, 32'(sv_o), 32'd1);
      check({tag, ".done"},     32'(dn_o), 32'(e.last));
      check({tag, ".busy"},     32'(bz_o), 32'd1);
    end else begin
      check({tag, ".so_idle"},       32'(so_o), 32'd0);
      check({tag, ".so_valid_idle"}, 32'(sv_o), 32'd0);
      check({tag, ".done_idle"},     32'(dn_o), 32'd0);
      check({tag, ".busy_idle"},     32'(bz_o), 32'd0);
    end
  endtask

  // One clock: model the accept, then compare outputs #1 after the edge.
  task automatic tick();
    logic         acc;
    logic [W-1:0] w;
    acc = load_valid && exp_ready && rst_n;
    w   = pi;
    @(posedge clk);
    #1;
    if (acc) push_frame(w);
    check_lane("msb", q0, so0, so_valid0, done0, busy0);
    check_lane("lsb", q1, so1, so_valid1, done1, busy1);
    exp_ready = (q0.size() == 0);
    check("msb.load_ready", 32'(ready0), 32'(exp_ready));
    check("lsb.load_ready", 32'(ready1), 32'(exp_ready));
  endtask

  initial begin
    // 1. Reset held for two cycles, then released idle.
    #1;
    check("rst.load_ready", 32'(ready0), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // 2. Single frame 1011 (1,0,1,1 MSB-first), then idle.
    pi = 4'b1011; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; pi = 4'b0000;   // pi changes mid-frame: no effect
    repeat (FL) tick();

    // 3. Back-to-back 1100 then 0011 with load_valid held high.
    pi = 4'b1100; load_valid = 1'b1;
    tick();
    pi = 4'b0011;                      // offered while not ready: held, not lost
    repeat (FL - 1) tick();
    tick();                            // accepted on the last bit of frame 1
    load_valid = 1'b0;
    repeat (FL) tick();

    // 4. 0001: LSB-first lane sends 1,0,0,0.
    pi = 4'b0001; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (FL) tick();

    // 5. Reset after two bits of 1111: outputs drop without a clock edge.
    pi = 4'b1111; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.so",         32'(so0),       32'd0);
    check("abort.so_valid",   32'(so_valid0), 32'd0);
    check("abort.busy",       32'(busy0),     32'd0);
    check("abort.load_ready", 32'(ready0),    32'd1);
    check("abort.lsb_so_v",   32'(so_valid1), 32'd0);
    q0.delete();
    q1.delete();
    exp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (W + 1) tick();             // nothing left over is sent

    // 6. Parity patterns 0111 and 0110, back to back.
    pi = 4'b0111; load_valid = 1'b1;
    tick();
    pi = 4'b0110;
    repeat (FL - 1) tick();
    tick();
    load_valid = 1'b0;
    repeat (FL + 1) tick();

    check("end.queue_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
